// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller.
//  - MEM_* request opcodes driven by the MEM stage.
//  - MEM_* access lengths (byte / half / word).
//  - ZERO_WORD, the cleared 32-bit data value.
package mem_ctrl_pkg;

  localparam logic [1:0] MEM_NOP  = 2'd0;
  localparam logic [1:0] MEM_LOAD = 2'd1;
  localparam logic [1:0] MEM_SAVE = 2'd2;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/mem_ctrl_bytelane.sv
// Byte-lane helper for mem_ctrl (purely combinational).
//  len       in   access length code (MEM_BYTE/HALF/WORD)
//  data      in   32-bit store word
//  dout_sel  in   byte lane of data to drive onto the RAM write bus
//  cap_en    in   a load byte is being captured this cycle
//  cap_sel   in   byte lane receiving the captured load byte
//  n_bytes   out  number of byte accesses for len (1, 2 or 4)
//  dout_byte out  selected store byte
//  lane_we   out  one-hot write enable into the load assembly word
module mem_ctrl_bytelane
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  len,
  input  logic [31:0] data,
  input  logic [1:0]  dout_sel,
  input  logic        cap_en,
  input  logic [1:0]  cap_sel,
  output logic [2:0]  n_bytes,
  output logic [7:0]  dout_byte,
  output logic [3:0]  lane_we
);

  // NOTE: every variable written in always_comb gets a value before any
  // branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    n_bytes = 3'd4;
    case (len)
      MEM_BYTE: n_bytes = 3'd1;
      MEM_HALF: n_bytes = 3'd2;
      default:  n_bytes = 3'd4;
    endcase
  end

  assign dout_byte = data[{dout_sel, 3'b000} +: 8];
  assign lane_we   = cap_en ? (4'b0001 << cap_sel) : 4'b0000;

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller between the pipeline and an 8-bit RAM.
// Serves the MEM data port (priority) and the IF fetch port; each request
// becomes 1/2/4 sequential little-endian byte accesses, and completion is
// reported with a one-cycle *_fin pulse.
//  clk_in, rst_n_in        clock, asynchronous active-low reset
//  rdy_in                  global ready; low freezes the controller
//  memctl_op/len/addr/data MEM request (held until memctl_fin)
//  memctl_fin, memctl_out  MEM completion pulse and zero-extended load data
//  if_req, if_addr         fetch request (always a 4-byte load)
//  if_fin, if_out          fetch completion pulse and fetched word
//  ram_din                 RAM read data for the previous cycle's ram_a
//  ram_dout, ram_a, ram_wr RAM write data, byte address, write strobe
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int RAM_AW = 17
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic [1:0]        memctl_op,
  input  logic [1:0]        memctl_len,
  input  logic [ADDR_W-1:0] memctl_addr,
  input  logic [31:0]       memctl_data,
  output logic              memctl_fin,
  output logic [31:0]       memctl_out,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_fin,
  output logic [31:0]       if_out,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_wr
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;
  typedef enum logic {SRC_MEM, SRC_IF} src_t;

  state_t            state_q, state_d;
  src_t              src_q;
  logic [ADDR_W-1:0] addr_q, next_addr;
  logic [31:0]       data_q, asm_q, asm_next;
  logic [1:0]        len_q;
  logic [2:0]        cnt_q, n_bytes;
  logic              wr_q, rdy_q;
  logic [7:0]        din_hold, din_eff, dout_byte;
  logic [3:0]        lane_we;
  logic [1:0]        dout_sel, cap_sel;
  logic              cap_en, mem_legal, load_last, store_last;

  assign mem_legal  = (memctl_op == MEM_LOAD || memctl_op == MEM_SAVE) &&
                      (memctl_len != 2'd3);
  assign next_addr  = addr_q + ADDR_W'(cnt_q) + ADDR_W'(1);
  assign load_last  = (cnt_q == n_bytes);
  assign store_last = (cnt_q == n_bytes - 3'd1);
  assign dout_sel   = cnt_q[1:0] + 2'd1;
  assign cap_sel    = cnt_q[1:0] - 2'd1;
  assign cap_en     = (state_q == LOAD) && (cnt_q != 3'd0);

  // ram_a runs one byte ahead of the capture, so across a freeze the RAM
  // output moves on to the held address. din_hold keeps the byte that was
  // on ram_din in the first frozen cycle and stands in for ram_din until one
  // active cycle has passed, so the pending byte is captured on resume.
  assign din_eff = rdy_q ? ram_din : din_hold;

  // The write strobe must drop in the very cycle rdy_in falls.
  assign ram_wr = wr_q & rdy_in;

  mem_ctrl_bytelane u_bytelane (
    .len       (len_q),
    .data      (data_q),
    .dout_sel  (dout_sel),
    .cap_en    (cap_en),
    .cap_sel   (cap_sel),
    .n_bytes   (n_bytes),
    .dout_byte (dout_byte),
    .lane_we   (lane_we)
  );

  always_comb begin
    asm_next = asm_q;
    for (int k = 0; k < 4; k++) begin
      if (lane_we[k]) asm_next[8*k +: 8] = din_eff;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mem_legal)   state_d = (memctl_op == MEM_LOAD) ? LOAD : STORE;
        else if (if_req) state_d = LOAD;
      end
      LOAD:    if (load_last)  state_d = DONE;
      STORE:   if (store_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)   state_q <= IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      src_q      <= SRC_MEM;
      addr_q     <= '0;
      data_q     <= ZERO_WORD;
      len_q      <= MEM_BYTE;
      cnt_q      <= 3'd0;
      asm_q      <= ZERO_WORD;
      wr_q       <= 1'b0;
      rdy_q      <= 1'b1;
      din_hold   <= 8'h00;
      ram_a      <= '0;
      ram_dout   <= 8'h00;
      memctl_fin <= 1'b0;
      memctl_out <= ZERO_WORD;
      if_fin     <= 1'b0;
      if_out     <= ZERO_WORD;
    end else begin
      rdy_q    <= rdy_in;
      din_hold <= din_eff;
      if (rdy_in) begin
        memctl_fin <= 1'b0;
        if_fin     <= 1'b0;
        case (state_q)
          IDLE: begin
            if (mem_legal || if_req) begin
              cnt_q <= 3'd0;
              asm_q <= ZERO_WORD;
              if (mem_legal) begin
                src_q    <= SRC_MEM;
                addr_q   <= memctl_addr;
                data_q   <= memctl_data;
                len_q    <= memctl_len;
                ram_a    <= memctl_addr[RAM_AW-1:0];
                ram_dout <= memctl_data[7:0];
                wr_q     <= (memctl_op == MEM_SAVE);
              end else begin
                src_q  <= SRC_IF;
                addr_q <= if_addr;
                data_q <= ZERO_WORD;
                len_q  <= MEM_WORD;
                ram_a  <= if_addr[RAM_AW-1:0];
              end
            end
          end
          LOAD: begin
            asm_q <= asm_next;
            if (load_last) begin
              if (src_q == SRC_MEM) begin
                memctl_fin <= 1'b1;
                memctl_out <= asm_next;
              end else begin
                if_fin <= 1'b1;
                if_out <= asm_next;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q + 3'd1 < n_bytes) ram_a <= next_addr[RAM_AW-1:0];
            end
          end
          STORE: begin
            if (store_last) begin
              wr_q       <= 1'b0;
              memctl_fin <= 1'b1;
            end else begin
              cnt_q    <= cnt_q + 3'd1;
              ram_a    <= next_addr[RAM_AW-1:0];
              ram_dout <= dout_byte;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
